// File: rtl/spi_pkg.sv
// spi_pkg: types and constants shared by the SPI master and responder.
// Holds the controller state encoding and the default SCLK divider.
package spi_pkg;

  localparam int SPI_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_HOLD  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_baud_tick.sv
// spi_baud_tick: half-period tick generator for the SPI master.
// Restart parks the counter so the first tick lands CLK_DIV cycles later.
module spi_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - ONE;
    end
  end

  assign tick = !restart && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI byte master with optional chip-select hold.
// One byte per accept; bursts keep cs_n low through the HOLD state.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cs_hold,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  spi_state_e state;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [2:0] bit_cnt;
  logic       hold_q;
  logic       tick;
  logic       restart;
  logic       accept;

  assign accept  = tx_valid && tx_ready;
  assign restart = (state == ST_IDLE) || (state == ST_HOLD);

  spi_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_ready <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      busy     <= 1'b0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      bit_cnt  <= 3'd0;
      hold_q   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            state    <= ST_SHIFT;
            tx_ready <= 1'b0;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            mosi     <= tx_data[7];
            tx_sr    <= tx_data;
            hold_q   <= cs_hold;
            bit_cnt  <= 3'd0;
          end else if (state == ST_HOLD && !cs_hold) begin
            state    <= ST_TRAIL;
            tx_ready <= 1'b0;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tick && !sclk) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
          end else if (tick) begin
            sclk <= 1'b0;
            // last falling edge closes the byte instead of shifting
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              mosi     <= 1'b0;
              if (hold_q) begin
                state    <= ST_HOLD;
                tx_ready <= 1'b1;
              end else begin
                state <= ST_TRAIL;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= tx_sr[6];
              tx_sr   <= {tx_sr[6:0], 1'b0};
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_n  <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master at CLK_DIV 1, 2 and 4.
// Random bytes and a slave model feed expectations to a decoupled monitor.
module tb_spi_master;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         acc;
    bit         hold;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit done [3];

  task automatic chk(input int cd, input string name, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (clk_div=%0d cyc=%0d): got 0x%0h, expected 0x%0h",
               name, cd, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : h
    localparam int CD = (g == 0) ? 1 : (g == 1) ? 2 : 4;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       cs_hold;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_bit;
    logic       cs_n;
    bit         lb;

    exp_t       exp_q[$];
    logic [7:0] slv_q[$];
    bit         pend_cs_on;
    bit         pend_rdy_on;
    bit         pend_busy;
    int         pend_cs;
    int         pend_rdy;

    assign miso = lb ? mosi : miso_bit;

    spi_master #(
      .CLK_DIV(CD)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .cs_hold (cs_hold),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .busy    (busy),
      .sclk    (sclk),
      .mosi    (mosi),
      .miso    (miso),
      .cs_n    (cs_n)
    );

    task automatic step();
      @(negedge clk);
      #1;
    endtask

    task automatic rst_vals_chk();
      chk(CD, "rst_cs_n", cs_n, 1);
      chk(CD, "rst_sclk", sclk, 0);
      chk(CD, "rst_mosi", mosi, 0);
      chk(CD, "rst_rx_valid", rx_valid, 0);
      chk(CD, "rst_rx_data", rx_data, 0);
      chk(CD, "rst_busy", busy, 0);
      chk(CD, "rst_tx_ready", tx_ready, 0);
    endtask

    task automatic do_release_rst();
      #1 rst_n = 1'b1;
      pend_rdy_on = 1'b1;
      pend_rdy = cyc + 1;
      pend_busy = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      step();
      while (tx_ready !== 1'b1 && n < 400) begin
        step();
        n++;
      end
      ok = (n < 400);
      if (!ok) chk(CD, "ready_timeout", n, 0);
    endtask

    task automatic send(input logic [7:0] d, input bit hold,
                        input logic [7:0] r, output int acc);
      exp_t e;
      bit ok;
      acc = 0;
      wait_ready(ok);
      if (!ok) return;
      tx_valid = 1'b1;
      tx_data = d;
      cs_hold = hold;
      slv_q.push_back(lb ? d : r);
      acc = cyc + 1;
      e.tx = d;
      e.rx = lb ? d : r;
      e.hold = hold;
      e.acc = acc;
      exp_q.push_back(e);
      for (int i = 0; i < 8; i++) begin
        step();
        tx_data = 8'($urandom);
        cs_hold = 1'($urandom);
      end
      tx_valid = 1'b0;
      cs_hold = hold;
      tx_data = 8'($urandom);
    endtask

    task automatic release_hold();
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      cs_hold = 1'b0;
      pend_cs_on = 1'b1;
      pend_cs = cyc + 1 + CD;
      pend_rdy_on = 1'b1;
      pend_rdy = cyc + 1 + 2 * CD;
      pend_busy = 1'b0;
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      step();
      while ((exp_q.size() > 0 || pend_rdy_on || pend_cs_on) && n < 3000) begin
        step();
        n++;
      end
      if (n >= 3000) chk(CD, "idle_timeout", n, 0);
    endtask

    initial begin : slave
      logic [7:0] cur;
      int idx;
      bit have;
      logic prev;
      cur = 8'h00;
      idx = 0;
      have = 1'b0;
      prev = 1'b0;
      miso_bit = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          idx = 0;
          have = 1'b0;
          slv_q.delete();
        end else begin
          if (prev && !sclk) begin
            idx++;
            if (idx == 8) begin
              idx = 0;
              have = 1'b0;
            end
          end
          if (!have && slv_q.size() > 0) begin
            cur = slv_q.pop_front();
            have = 1'b1;
          end
        end
        prev = sclk;
        miso_bit = have ? cur[7-idx] : 1'b0;
      end
    end

    initial begin : mon
      logic p_sclk, p_cs, p_rdy, p_rxv;
      logic [7:0] macc;
      int rises;
      exp_t e;
      p_sclk = 1'b0;
      p_cs = 1'b1;
      p_rdy = 1'b0;
      p_rxv = 1'b0;
      macc = 8'h00;
      rises = 0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          rises = 0;
        end else begin
          if (sclk && !p_sclk) begin
            rises++;
            macc = {macc[6:0], mosi};
          end
          if (rx_valid) begin
            chk(CD, "rxv_one_cycle", p_rxv, 0);
            chk(CD, "rxv_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk(CD, "rx_data", rx_data, e.rx);
              chk(CD, "mosi_bits", macc, e.tx);
              chk(CD, "rxv_time", cyc, e.acc + 16 * CD);
              chk(CD, "sclk_rises", rises, 8);
              chk(CD, "busy_byte", busy, 1);
              pend_rdy_on = 1'b1;
              pend_busy = e.hold;
              if (e.hold) begin
                pend_rdy = e.acc + 16 * CD;
              end else begin
                pend_cs_on = 1'b1;
                pend_cs = e.acc + 17 * CD;
                pend_rdy = e.acc + 18 * CD;
              end
            end
            rises = 0;
          end
          if (cs_n && !p_cs) begin
            chk(CD, "cs_rise_expected", pend_cs_on, 1);
            if (pend_cs_on) chk(CD, "cs_rise_time", cyc, pend_cs);
            pend_cs_on = 1'b0;
          end
          if (tx_ready && !p_rdy) begin
            chk(CD, "rdy_rise_expected", pend_rdy_on, 1);
            if (pend_rdy_on) begin
              chk(CD, "rdy_rise_time", cyc, pend_rdy);
              chk(CD, "busy_at_ready", busy, pend_busy);
            end
            chk(CD, "mosi_at_ready", mosi, 0);
            pend_rdy_on = 1'b0;
          end
        end
        p_sclk = sclk;
        p_cs = cs_n;
        p_rdy = tx_ready;
        p_rxv = rx_valid;
      end
    end

    initial begin : stim
      int acc;
      int n;
      bit hold;
      rst_n = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      cs_hold = 1'b0;
      lb = 1'b0;
      pend_cs_on = 1'b0;
      pend_rdy_on = 1'b0;
      pend_busy = 1'b0;
      pend_cs = 0;
      pend_rdy = 0;
      repeat (3) step();
      rst_vals_chk();
      do_release_rst();

      lb = 1'b1;
      send(8'hA5, 1'b0, 8'h00, acc);
      wait_idle();
      lb = 1'b0;

      send(8'hFF, 1'b0, 8'h3C, acc);
      wait_idle();

      send(8'h01, 1'b1, 8'($urandom), acc);
      send(8'h02, 1'b1, 8'($urandom), acc);
      send(8'h03, 1'b0, 8'($urandom), acc);
      wait_idle();

      send(8'($urandom), 1'b1, 8'($urandom), acc);
      release_hold();
      wait_idle();

      send(8'($urandom), 1'b1, 8'($urandom), acc);
      send(8'($urandom), 1'b0, 8'($urandom), acc);
      wait_idle();

      send(8'h55, 1'b0, 8'($urandom), acc);
      while (cyc < acc + 9) step();
      rst_n = 1'b0;
      #1;
      chk(CD, "abort_cs_n", cs_n, 1);
      chk(CD, "abort_sclk", sclk, 0);
      chk(CD, "abort_rx_valid", rx_valid, 0);
      exp_q.delete();
      pend_cs_on = 1'b0;
      pend_rdy_on = 1'b0;
      repeat (2) step();
      rst_vals_chk();
      do_release_rst();
      send(8'($urandom), 1'b0, 8'($urandom), acc);
      wait_idle();

      hold = 1'b0;
      for (int i = 0; i < 20; i++) begin
        hold = 1'($urandom);
        send(8'($urandom), hold, 8'($urandom), acc);
        if (hold && $urandom_range(0, 2) == 0) begin
          release_hold();
          wait_idle();
        end
      end
      send(8'($urandom), 1'b0, 8'($urandom), acc);
      wait_idle();
      n = 0;
      while ((tx_ready !== 1'b1 || busy !== 1'b0) && n < 200) begin
        step();
        n++;
      end
      chk(CD, "final_busy", busy, 0);
      chk(CD, "final_queue", exp_q.size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin : top
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk(0, "all_done", int'(done[0] && done[1] && done[2]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, is the SCLK half-period in clk cycles; legal range 1..255.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 tx_data  in  8  byte to transmit, MSB first.
REQ-006 tx_valid  in  1  request to start a byte.
REQ-007 tx_ready  out  1  block can accept a byte; transfer occurs when tx_valid and tx_ready are both high on a clk edge.
REQ-008 cs_hold  in  1  sampled at accept; 1 keeps cs_n low after the byte for a burst.
REQ-009 rx_data  out  8  byte received on miso; stable until the next rx_valid.
REQ-010 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-011 busy  out  1  high whenever cs_n is low or trailing hold time runs.
REQ-012 sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 mosi  out  1  serial data out.
REQ-014 miso  in  1  serial data in; synchronous to clk at the bench, no synchronizer inside.
REQ-015 cs_n  out  1  active-low chip select.

Function
REQ-016 States SHALL be IDLE, SHIFT, HOLD, TRAIL, GAP.
REQ-017 IDLE: tx_ready=1, cs_n=1, sclk=0, mosi=0; on accept (edge 0) SHALL go to SHIFT with cs_n=0 and mosi=tx_data[7] from edge 0.
REQ-018 SHIFT: sclk SHALL rise at edges CLK_DIV*(2k+1) and fall at CLK_DIV*(2k+2), k=0..7, relative to accept edge.
REQ-019 miso SHALL be sampled into the shift register on each sclk rising edge; mosi SHALL update to the next bit on each falling edge except the 8th.
REQ-020 At edge 16*CLK_DIV: rx_data SHALL load the 8 sampled bits (first sampled = bit 7), rx_valid SHALL pulse for exactly one cycle, mosi SHALL return to 0.
REQ-021 After a byte with latched cs_hold=0 the FSM SHALL enter TRAIL: cs_n low for CLK_DIV more cycles, then cs_n=1 and GAP for CLK_DIV cycles, then IDLE.
REQ-022 After a byte with latched cs_hold=1 the FSM SHALL enter HOLD: cs_n=0, sclk=0, tx_ready=1; an accept SHALL start the next byte with REQ-017..020 timing, no CS setup.
REQ-023 In HOLD, cs_hold=0 with tx_valid=0 SHALL move to TRAIL; tx_valid=1 takes priority over release.
REQ-024 tx_ready SHALL be 0 in SHIFT, TRAIL, GAP; tx_valid while not ready SHALL be ignored, no queuing.
REQ-025 tx_data and cs_hold SHALL be captured only at accept; later changes have no effect on the current byte.
REQ-026 Divider counter SHALL be ceil(log2(CLK_DIV+1)) bits and reload to CLK_DIV-1 without wrap error; bit counter 3 bits, terminal at 7.
REQ-027 CLK_DIV=1 SHALL yield sclk = clk/2 with identical edge rules.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0x00, busy=0, tx_ready=0.
REQ-029 tx_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-byte SHALL abort with no rx_valid.

Structure
REQ-030 Package spi_pkg SHALL hold the state enum and the default CLK_DIV constant, shared with the existing SPI responder.
REQ-031 One sub-module spi_baud_tick SHALL generate the half-period tick from CLK_DIV with a synchronous restart input.

Verification
REQ-032 CLK_DIV=2, miso looped to mosi, send 0xA5, cs_hold=0 -> rx_valid at accept+32, rx_data=0xA5, cs_n high at accept+34, tx_ready at accept+36.
REQ-033 CLK_DIV=4, miso driven by model returning 0x3C, send 0xFF -> mosi all ones over 8 sclk pulses, rx_data=0x3C, exactly 8 sclk rises.
REQ-034 CLK_DIV=1, burst 0x01,0x02,0x03 with cs_hold=1,1,0 -> cs_n low continuously across 24 sclk pulses, three rx_valid pulses, cs_n high 1 cycle after last.
REQ-035 HOLD with cs_hold=0 and tx_valid=0 -> TRAIL then IDLE; same cycle with tx_valid=1 -> next byte accepted, cs_n stays low.
REQ-036 rst_n pulsed low at accept+10 of byte 0x55 -> cs_n=1, sclk=0 immediately, no rx_valid, next byte after reset completes normally.
REQ-037 tx_valid held high during SHIFT with changing tx_data -> only the byte at accept transmitted, bit-exact.
